// File: rtl/cpu_pkg.sv
// Shared CPU control definitions: decoder status codes, sequencer states, data-source codes.
package cpu_pkg;

    typedef enum logic [2:0] {
        TO_NOP     = 3'b000,
        RAM_READ   = 3'b001,
        ROM_READ   = 3'b010,
        PROCESS    = 3'b011,
        RAM_WRITE  = 3'b100,
        INS_DECODE = 3'b101,
        NOT_DONE   = 3'b111
    } next_status_e;

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        RD_RAM = 3'd2,
        RD_ROM = 3'd3,
        PROC   = 3'd4,
        WR_RAM = 3'd5
    } state_e;

    typedef enum logic [1:0] {
        FROM_A            = 2'd0,
        FROM_RAM_DATA_REG = 2'd1,
        FROM_ROM_DATA_REG = 2'd2,
        NO_USED           = 2'd3
    } data_src_e;

endpackage

// File: rtl/exec_sequencer_if.sv
// ROM/RAM request-acknowledge bus between the execution sequencer and the memories.
interface exec_sequencer_if #(parameter int PC_W = 16);
    logic            rom_rd_req;
    logic            rom_rd_ack;
    logic [PC_W-1:0] rom_addr;
    logic [7:0]      rom_rdata;
    logic            ram_rd_req;
    logic            ram_rd_ack;
    logic            ram_wr_req;
    logic            ram_wr_ack;
    logic [7:0]      ram_addr;
    logic [7:0]      ram_rdata;

    modport master (
        output rom_rd_req, rom_addr, ram_rd_req, ram_wr_req, ram_addr,
        input  rom_rd_ack, rom_rdata, ram_rd_ack, ram_rdata, ram_wr_ack
    );

    modport slave (
        input  rom_rd_req, rom_addr, ram_rd_req, ram_wr_req, ram_addr,
        output rom_rd_ack, rom_rdata, ram_rd_ack, ram_rdata, ram_wr_ack
    );
endinterface

// File: rtl/bus_wait_timer.sv
// Counts unacknowledged bus-wait cycles; expired holds once LIMIT cycles have elapsed.
module bus_wait_timer #(
    parameter int LIMIT = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic tick,
    output logic expired
);
    localparam logic [3:0] LIM = 4'(LIMIT);

    logic [3:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            cnt <= 4'd0;
        end else if (tick && !expired) begin
            cnt <= cnt + 4'd1;
        end
    end

    assign expired = (cnt == LIM);
endmodule

// File: rtl/exec_sequencer.sv
// Main CPU control FSM: fetches opcodes and runs the decoder's per-phase bus steps.
// Optional bus-ack timeout is built when EXEC_SEQ_TIMEOUT_EN is defined.
//
// state  | meaning
// FETCH  | read opcode at pc from ROM
// DECODE | load phase count (first pass) or dispatch next_status
// RD_RAM | RAM read into ram_data_register
// RD_ROM | ROM operand read into rom_data_register, pc advances
// PROC   | one-cycle ALU strobe
// WR_RAM | RAM write
module exec_sequencer
    import cpu_pkg::*;
#(
    parameter int PC_W        = 16,
    parameter int TIMEOUT_CYC = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    exec_sequencer_if.master  bus,
    input  logic [2:0]        next_status,
    input  logic [2:0]        run_phase_init,
    input  logic [7:0]        addr_register_in,
    output logic [7:0]        instruction,
    output logic [2:0]        run_phase,
    output logic [7:0]        ram_data_register,
    output logic [7:0]        rom_data_register,
    output logic              alu_en,
    output logic [PC_W-1:0]   pc,
    output logic              illegal
);
    localparam logic [PC_W-1:0] PC_ONE = PC_W'(1);

    state_e     state, state_nxt;
    logic       first;
    logic [7:0] ram_addr_q;
    logic       rom_req_c, ram_rd_req_c, ram_wr_req_c, alu_c, illegal_c;
    logic       ld_instr, load_phase, latch_addr, ld_ram, ld_rom, step_done, abort;
    logic       timed_out;

`ifdef EXEC_SEQ_TIMEOUT_EN
    logic waiting, ack_active, tmr_clr;

    assign waiting = (state == FETCH) || (state == RD_RAM) ||
                     (state == RD_ROM) || (state == WR_RAM);

    always_comb begin
        ack_active = 1'b0;
        case (state)
            FETCH, RD_ROM: ack_active = bus.rom_rd_ack;
            RD_RAM:        ack_active = bus.ram_rd_ack;
            WR_RAM:        ack_active = bus.ram_wr_ack;
            default:       ack_active = 1'b0;
        endcase
    end

    // Restart the count on every state change, including a timed-out refetch.
    assign tmr_clr = !waiting || timed_out || (state_nxt != state);

    bus_wait_timer #(.LIMIT(TIMEOUT_CYC)) u_bus_wait_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (tmr_clr),
        .tick    (waiting && !ack_active),
        .expired (timed_out)
    );
`else
    assign timed_out = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) state <= FETCH;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt    = state;
        rom_req_c    = 1'b0;
        ram_rd_req_c = 1'b0;
        ram_wr_req_c = 1'b0;
        alu_c        = 1'b0;
        illegal_c    = 1'b0;
        ld_instr     = 1'b0;
        load_phase   = 1'b0;
        latch_addr   = 1'b0;
        ld_ram       = 1'b0;
        ld_rom       = 1'b0;
        step_done    = 1'b0;
        abort        = 1'b0;
        case (state)
            FETCH: begin
                if (timed_out) begin
                    abort = 1'b1;
                end else begin
                    rom_req_c = 1'b1;
                    if (bus.rom_rd_ack) begin
                        ld_instr  = 1'b1;
                        state_nxt = DECODE;
                    end
                end
            end
            DECODE: begin
                if (first) begin
                    load_phase = 1'b1;
                end else begin
                    case (next_status_e'(next_status))
                        RAM_READ:  begin state_nxt = RD_RAM; latch_addr = 1'b1; end
                        ROM_READ:  state_nxt = RD_ROM;
                        PROCESS:   state_nxt = PROC;
                        RAM_WRITE: begin state_nxt = WR_RAM; latch_addr = 1'b1; end
                        NOT_DONE:  begin state_nxt = FETCH; illegal_c = 1'b1; end
                        default:   state_nxt = FETCH;
                    endcase
                end
            end
            RD_RAM: begin
                if (timed_out) begin
                    abort = 1'b1;
                end else begin
                    ram_rd_req_c = 1'b1;
                    ld_ram       = bus.ram_rd_ack;
                    step_done    = bus.ram_rd_ack;
                end
            end
            RD_ROM: begin
                if (timed_out) begin
                    abort = 1'b1;
                end else begin
                    rom_req_c = 1'b1;
                    ld_rom    = bus.rom_rd_ack;
                    step_done = bus.rom_rd_ack;
                end
            end
            PROC: begin
                alu_c     = 1'b1;
                step_done = 1'b1;
            end
            WR_RAM: begin
                if (timed_out) begin
                    abort = 1'b1;
                end else begin
                    ram_wr_req_c = 1'b1;
                    step_done    = bus.ram_wr_ack;
                end
            end
            default: state_nxt = FETCH;
        endcase
        if (step_done) state_nxt = (run_phase <= 3'd1) ? FETCH : DECODE;
        if (abort) begin
            illegal_c = 1'b1;
            state_nxt = FETCH;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            first             <= 1'b0;
            instruction       <= 8'd0;
            run_phase         <= 3'd0;
            pc                <= '0;
            ram_addr_q        <= 8'd0;
            ram_data_register <= 8'd0;
            rom_data_register <= 8'd0;
        end else begin
            if (ld_instr) begin
                instruction <= bus.rom_rdata;
                pc          <= pc + PC_ONE;
                first       <= 1'b1;
            end
            if (load_phase) begin
                run_phase <= run_phase_init;
                first     <= 1'b0;
            end
            if (latch_addr) ram_addr_q <= addr_register_in;
            if (ld_ram) ram_data_register <= bus.ram_rdata;
            if (ld_rom) begin
                rom_data_register <= bus.rom_rdata;
                pc                <= pc + PC_ONE;
            end
            if (step_done) run_phase <= (run_phase <= 3'd1) ? 3'd0 : run_phase - 3'd1;
            if (abort) run_phase <= 3'd0;
        end
    end

    // Strobes are gated by rst_n so every request drops while reset is held.
    assign bus.rom_rd_req = rom_req_c & rst_n;
    assign bus.ram_rd_req = ram_rd_req_c & rst_n;
    assign bus.ram_wr_req = ram_wr_req_c & rst_n;
    assign bus.rom_addr   = pc;
    assign bus.ram_addr   = ram_addr_q;
    assign alu_en         = alu_c & rst_n;
    assign illegal        = illegal_c & rst_n;
endmodule

// File: tb/tb_exec_sequencer.sv
// Self-checking bench for exec_sequencer: directed plan steps plus randomized instruction streams.
module tb_exec_sequencer;
    import cpu_pkg::*;

    localparam int PC_W = 16;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [2:0]      next_status = 3'd0;
    logic [2:0]      run_phase_init = 3'd0;
    logic [7:0]      addr_register_in = 8'd0;
    logic [7:0]      instruction, ram_data_register, rom_data_register;
    logic [2:0]      run_phase;
    logic            alu_en, illegal;
    logic [PC_W-1:0] pc;

    exec_sequencer_if #(.PC_W(PC_W)) bus ();

    exec_sequencer #(.PC_W(PC_W), .TIMEOUT_CYC(15)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .bus               (bus),
        .next_status       (next_status),
        .run_phase_init    (run_phase_init),
        .addr_register_in  (addr_register_in),
        .instruction       (instruction),
        .run_phase         (run_phase),
        .ram_data_register (ram_data_register),
        .rom_data_register (rom_data_register),
        .alu_en            (alu_en),
        .pc                (pc),
        .illegal           (illegal)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference state: what the spec says the sequencer must hold.
    logic [15:0] m_pc = 16'd0;
    logic [7:0]  m_ram = 8'd0, m_rom = 8'd0, m_instr = 8'd0, cur_addr = 8'd0;
    logic [2:0]  prog_st [8];
    logic [7:0]  prog_ad [8];
    int          prog_w  [8];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic idle_acks(input int own);
        bus.rom_rd_ack = (own == 1) ? 1'b0 : 1'($urandom_range(0, 1));
        bus.ram_rd_ack = (own == 2) ? 1'b0 : 1'($urandom_range(0, 1));
        bus.ram_wr_ack = (own == 3) ? 1'b0 : 1'($urandom_range(0, 1));
        bus.rom_rdata  = 8'($urandom);
        bus.ram_rdata  = 8'($urandom);
    endtask

    task automatic zero_acks();
        bus.rom_rd_ack = 1'b0;
        bus.ram_rd_ack = 1'b0;
        bus.ram_wr_ack = 1'b0;
    endtask

    // One handshaked step on channel ch (1 rom read, 2 ram read, 3 ram write), ack after w waits.
    task automatic bus_wait(input int ch, input int w, input logic [7:0] data);
        for (int i = 0; i <= w; i++) begin
            chk("req_rom", bus.rom_rd_req, ch == 1);
            chk("req_ram_rd", bus.ram_rd_req, ch == 2);
            chk("req_ram_wr", bus.ram_wr_req, ch == 3);
            if (ch == 1) chk("rom_addr", bus.rom_addr, m_pc);
            else         chk("ram_addr", bus.ram_addr, cur_addr);
            chk("alu_quiet", alu_en, 1'b0);
            idle_acks(ch);
            case (ch)
                1: begin bus.rom_rd_ack = (i == w); if (i == w) bus.rom_rdata = data; end
                2: begin bus.ram_rd_ack = (i == w); if (i == w) bus.ram_rdata = data; end
                default: bus.ram_wr_ack = (i == w);
            endcase
            @(negedge clk);
        end
    endtask

    task automatic fetch_and_load(input logic [7:0] op, input logic [2:0] init, input int fw);
        run_phase_init = init;
        bus_wait(1, fw, op);
        m_pc    = m_pc + 16'd1;
        m_instr = op;
        chk("instr", instruction, m_instr);
        chk("pc_fetch", pc, m_pc);
        chk("dec1_noreq", {bus.rom_rd_req, bus.ram_rd_req, bus.ram_wr_req}, 3'b000);
        idle_acks(0);
        next_status = 3'($urandom);
        #1;
        chk("dec1_illegal", illegal, 1'b0);
        @(negedge clk);
    endtask

    task automatic run_prog(input logic [7:0] op, input logic [2:0] init, input int fw);
        int k;
        logic [2:0] ph;
        logic done;
        logic [7:0] d;
        fetch_and_load(op, init, fw);
        ph = init;
        k = 0;
        done = 1'b0;
        while (!done && k < 8) begin
            chk("phase", run_phase, ph);
            chk("dec_noreq", {bus.rom_rd_req, bus.ram_rd_req, bus.ram_wr_req}, 3'b000);
            next_status      = prog_st[k];
            addr_register_in = prog_ad[k];
            idle_acks(0);
            #1;
            chk("illegal", illegal, prog_st[k] == 3'b111);
            chk("dec_alu", alu_en, 1'b0);
            @(negedge clk);
            d = 8'($urandom);
            case (prog_st[k])
                3'b001: begin cur_addr = prog_ad[k]; bus_wait(2, prog_w[k], d); m_ram = d; end
                3'b010: begin bus_wait(1, prog_w[k], d); m_rom = d; m_pc = m_pc + 16'd1; end
                3'b011: begin
                    chk("alu_on", alu_en, 1'b1);
                    chk("proc_noreq", {bus.rom_rd_req, bus.ram_rd_req, bus.ram_wr_req}, 3'b000);
                    idle_acks(0);
                    @(negedge clk);
                end
                3'b100: begin cur_addr = prog_ad[k]; bus_wait(3, prog_w[k], d); end
                default: done = 1'b1;
            endcase
            if (!done) begin
                chk("ram_data_reg", ram_data_register, m_ram);
                chk("rom_data_reg", rom_data_register, m_rom);
                chk("pc_step", pc, m_pc);
                if (ph <= 3'd1) begin
                    done = 1'b1;
                    chk("phase_end", run_phase, 3'd0);
                end else begin
                    ph = ph - 3'd1;
                end
            end
            k++;
        end
        chk("refetch_req", bus.rom_rd_req, 1'b1);
        chk("refetch_addr", bus.rom_addr, m_pc);
        chk("refetch_alu", alu_en, 1'b0);
        chk("refetch_illegal", illegal, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        zero_acks();
        bus.rom_rdata = 8'd0;
        bus.ram_rdata = 8'd0;
        repeat (3) @(negedge clk);
        chk("rst_reqs", {bus.rom_rd_req, bus.ram_rd_req, bus.ram_wr_req}, 3'b000);
        chk("rst_instr", instruction, 8'd0);
        chk("rst_phase", run_phase, 3'd0);
        chk("rst_pc", pc, 16'd0);
        chk("rst_regs", {ram_data_register, rom_data_register}, 16'd0);
        chk("rst_strobes", {alu_en, illegal}, 2'b00);
        rst_n = 1'b1;
        #1;

        // F8 fetched with zero wait, one PROCESS phase
        prog_st[0] = 3'b011; prog_ad[0] = 8'h00; prog_w[0] = 0;
        run_prog(8'hF8, 3'd1, 0);

        // four phases: ROM read, two RAM reads, RAM write; RAM acks after 2 waits
        prog_st[0] = 3'b010; prog_w[0] = 0; prog_ad[0] = 8'h10;
        prog_st[1] = 3'b001; prog_w[1] = 2; prog_ad[1] = 8'h21;
        prog_st[2] = 3'b001; prog_w[2] = 2; prog_ad[2] = 8'h32;
        prog_st[3] = 3'b100; prog_w[3] = 2; prog_ad[3] = 8'h43;
        run_prog(8'h3C, 3'd4, 1);

        // NOT_DONE aborts the instruction
        prog_st[0] = 3'b111; prog_ad[0] = 8'h00; prog_w[0] = 0;
        run_prog(8'h77, 3'd2, 0);

        // init 0 still executes exactly one step
        prog_st[0] = 3'b001; prog_ad[0] = 8'hA5; prog_w[0] = 1;
        run_prog(8'h01, 3'd0, 2);

        // reset asserted during a RAM read wait
        fetch_and_load(8'h11, 3'd3, 0);
        next_status = 3'b001;
        addr_register_in = 8'h5A;
        idle_acks(0);
        @(negedge clk);
        chk("mid_req", bus.ram_rd_req, 1'b1);
        idle_acks(2);
        @(negedge clk);
        chk("mid_req_hold", bus.ram_rd_req, 1'b1);
        rst_n = 1'b0;
        zero_acks();
        @(posedge clk);
        #1;
        chk("mid_rst_reqs", {bus.rom_rd_req, bus.ram_rd_req, bus.ram_wr_req}, 3'b000);
        chk("mid_rst_pc", pc, 16'd0);
        chk("mid_rst_instr", instruction, 8'd0);
        chk("mid_rst_phase", run_phase, 3'd0);
        chk("mid_rst_regs", {ram_data_register, rom_data_register}, 16'd0);
        m_pc = 16'd0; m_ram = 8'd0; m_rom = 8'd0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("post_rst_fetch", bus.rom_rd_req, 1'b1);
        chk("post_rst_addr", bus.rom_addr, 16'd0);

`ifdef EXEC_SEQ_TIMEOUT_EN
        fetch_and_load(8'h55, 3'd3, 1);
        next_status = 3'b001;
        addr_register_in = 8'h66;
        idle_acks(0);
        @(negedge clk);
        for (int i = 0; i < 15; i++) begin
            chk("tmo_req_hold", bus.ram_rd_req, 1'b1);
            idle_acks(2);
            @(negedge clk);
        end
        chk("tmo_req_drop", bus.ram_rd_req, 1'b0);
        chk("tmo_illegal", illegal, 1'b1);
        zero_acks();
        @(negedge clk);
        chk("tmo_refetch", bus.rom_rd_req, 1'b1);
        chk("tmo_pc", bus.rom_addr, m_pc);
        chk("tmo_phase", run_phase, 3'd0);
        chk("tmo_illegal_off", illegal, 1'b0);
`endif

        for (int n = 0; n < 40; n++) begin
            logic [2:0] init;
            init = 3'($urandom_range(0, 5));
            for (int s = 0; s < 8; s++) begin
                int r;
                r = $urandom_range(0, 11);
                if (r < 10)       prog_st[s] = 3'((r % 4) + 1);
                else if (r == 10) prog_st[s] = ($urandom_range(0, 1) != 0) ? 3'b000 : 3'b101;
                else              prog_st[s] = 3'b111;
                prog_ad[s] = 8'($urandom);
                prog_w[s]  = $urandom_range(0, 3);
            end
            run_prog(8'($urandom), init, $urandom_range(0, 3));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/exec_sequencer.md
Name: exec_sequencer

Overview:
Main CPU control FSM that sequences the instruction decoder's per-phase requests against the ROM, RAM and ALU.
- Fetches each opcode into the instruction register and loads the decoder's run-phase count.
- Dispatches every decoder status code (RAM read, ROM read, process, RAM write) as one handshaked bus step.
- Decrements run_phase after each step; returns to fetch when the instruction finishes.
- Owns the program counter.

Parameters:
PC_W, 16, program counter / ROM address width
TIMEOUT_CYC, 15, maximum wait cycles for a bus ack; used only with the optional feature

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  reset, synchronous, active-low
next_status  in  3  decoder request: 000 NOP, 001 RAM_READ, 010 ROM_READ, 011 PROCESS, 100 RAM_WRITE, 101 INS_DECODE, 111 NOT_DONE
run_phase_init  in  3  decoder phase count for the current opcode
addr_register_in  in  8  decoder RAM address for the current step
rom_rd_ack  in  1  ROM read-data valid
rom_rdata  in  8  ROM read data
ram_rd_ack  in  1  RAM read-data valid
ram_rdata  in  8  RAM read data
ram_wr_ack  in  1  RAM write accepted
instruction  out  8  instruction register
run_phase  out  3  current phase, to decoder
rom_rd_req  out  1  ROM read request
rom_addr  out  PC_W  ROM address (= pc)
ram_rd_req  out  1  RAM read request
ram_wr_req  out  1  RAM write request
ram_addr  out  8  RAM address
ram_data_register  out  8  last RAM read data
rom_data_register  out  8  last ROM operand byte
alu_en  out  1  one-cycle ALU execute strobe
pc  out  PC_W  program counter
illegal  out  1  one-cycle pulse on NOT_DONE dispatch

Behaviour:
- Reset: all outputs, registers and pc are 0; state = FETCH. A reset asserted mid-step abandons the step on the next clock edge and drops every request.
- States: FETCH, DECODE, RD_RAM, RD_ROM, PROC, WR_RAM.
- FETCH:
  - rom_rd_req=1, rom_addr=pc.
  - On rom_rd_ack: instruction<=rom_rdata; pc<=pc+1 (wraps at 2^PC_W); run_phase<=run_phase_init is NOT done here; go to DECODE with first=1.
- DECODE (1 cycle, no requests):
  - If first: run_phase<=run_phase_init; clear first; stay in DECODE one more cycle so the decoder sees the loaded phase.
  - Else sample next_status:
    - 001 -> RD_RAM, latch ram_addr<=addr_register_in.
    - 010 -> RD_ROM.
    - 011 -> PROC.
    - 100 -> WR_RAM, latch ram_addr<=addr_register_in.
    - 000 or 101 -> FETCH.
    - 111 -> pulse illegal, then FETCH.
- Request rules:
  - Each request is held high until its own ack. The cycle an ack is seen completes the step, and the request drops the following cycle.
  - Acks on non-requested channels are ignored.
- RD_RAM: on ram_rd_ack, ram_data_register<=ram_rdata.
- RD_ROM: on rom_rd_ack, rom_data_register<=rom_rdata and pc<=pc+1.
- WR_RAM: completes on ram_wr_ack.
- PROC: alu_en=1 for exactly one cycle; always completes in 1 cycle.
- Step completion:
  - If run_phase<=1: run_phase<=0, next state FETCH.
  - Else run_phase<=run_phase-1, next state DECODE.
  - run_phase never underflows; init=0 executes exactly one step.
- Latency with zero-wait memory (ack in the request cycle): fetch 1 cycle, decode 2 cycles, each step 1 cycle.
- Multiple acks in one cycle: only the ack of the active state is honoured.

Optional Feature:
- Macro: EXEC_SEQ_TIMEOUT_EN.
- With it: a 4-bit wait counter clears on entry to any request state and increments each cycle without an ack. When it reaches TIMEOUT_CYC:
  - the request drops;
  - illegal pulses;
  - the FSM goes to FETCH;
  - run_phase<=0;
  - pc is unchanged for a timed-out ROM read.
- Without it: the FSM waits indefinitely.

Decomposition:
- Shared package cpu_pkg holds:
  - next_status codes (TO_NOP .. NOT_DONE);
  - the state enum;
  - data-source codes FROM_A, FROM_RAM_DATA_REG, FROM_ROM_DATA_REG, NO_USED.
- One sub-module, bus_wait_timer (counter plus timeout compare), instantiated only under EXEC_SEQ_TIMEOUT_EN.

Test Plan:
- Reset, then release with rom_rdata=8'hF8 and ack tied high -> instruction=F8 after 1 cycle; pc=1; run_phase=run_phase_init (1) in the decode cycle.
- run_phase_init=4, statuses 010,001,001,100, RAM acks after 2 wait cycles -> run_phase sequence 4,3,2,1; ram_rd_req held 3 cycles each; return to FETCH; pc=2.
- next_status=011 -> alu_en high exactly 1 cycle; then FETCH when run_phase=1.
- next_status=111 -> illegal pulses once; next cycle rom_rd_req=1 with rom_addr=pc.
- rst_n low during an RD_RAM wait -> next edge: all requests 0, pc=0, state FETCH.
- With EXEC_SEQ_TIMEOUT_EN and TIMEOUT_CYC=15, ram_rd_ack held low -> request drops after 15 cycles; illegal pulses; FSM refetches.
